axi_shim_arbiter: RTL and testbench

Shares one AXI shim request/response interface between `NumPorts` requesters, for example the instruction cache, the data cache and an uncached bypass. Read and write channels are arbitrated independently with round-robin fairness. Once a port is selected, it stays selected until the shim grants it. Responses return to the issuing port by AXI ID, and a per-port outstanding counter applies backpressure. The block sits directly in front of the shim's `rd_*`/`wr_*` request ports and adds no pipeline latency.

---
 rtl/axi_shim_arbiter.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_axi_shim_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_shim_arbiter.sv
// Round-robin arbiter that shares one AXI shim between NumPorts requesters.
// Read and write channels are arbitrated independently; responses return by AXI ID.

module axi_shim_rr_arb #(
  parameter int unsigned NumPorts       = 3,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned AxiIdWidth     = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumPorts-1:0]           req_i,
  input  logic                          shim_gnt_i,
  input  logic                          rsp_done_i,
  input  logic [AxiIdWidth-1:0]         rsp_id_i,
  output logic                          shim_req_o,
  output logic [$clog2(NumPorts)-1:0]   idx_o,
  output logic [NumPorts-1:0]           gnt_o
);

  localparam int unsigned IdxW = $clog2(NumPorts);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]                     state_q, state_d;
  logic [IdxW-1:0]                sel_q, sel_d;
  logic [IdxW-1:0]                rr_q, rr_d;
  logic [NumPorts-1:0][CntW-1:0]  cnt_q, cnt_d;

  logic [NumPorts-1:0] eligible;
  logic [NumPorts-1:0] dec_hit;
  logic                pick_valid;
  logic [IdxW-1:0]     pick_idx;
  logic [IdxW-1:0]     cand;

  function automatic logic [IdxW-1:0] wrap_add(input logic [IdxW-1:0] idx,
                                               input int unsigned off);
    return IdxW'((32'(idx) + off) % NumPorts);
  endfunction

  always_comb begin
    for (int unsigned p = 0; p < NumPorts; p++) begin
      eligible[p] = req_i[p] && (cnt_q[p] < CntMax);
      dec_hit[p]  = rsp_done_i && (rsp_id_i == AxiIdWidth'(p));
    end
  end

  // Scan offsets from the far end down so the port closest to rr_q wins last.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = NumPorts; i > 0; i--) begin
      cand = wrap_add(rr_q, i - 1);
      if (eligible[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    rr_d       = rr_q;
    shim_req_o = 1'b0;
    gnt_o      = '0;
    idx_o      = pick_idx;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          shim_req_o = 1'b1;
          if (shim_gnt_i) begin
            gnt_o[pick_idx] = 1'b1;
            rr_d            = wrap_add(pick_idx, 1);
          end else begin
            sel_d   = pick_idx;
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        idx_o   = sel_q;
        state_d = IDLE;
        if (!req_i[sel_q]) begin
          state_d = IDLE;
        end else begin
          shim_req_o = 1'b1;
          if (shim_gnt_i) begin
            gnt_o[sel_q] = 1'b1;
            rr_d         = wrap_add(sel_q, 1);
          end else begin
            state_d = LOCKED;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst_i) begin
      shim_req_o = 1'b0;
      gnt_o      = '0;
    end
  end

  // Simultaneous grant and completion cancel; the guards stop wrap in either direction.
  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned p = 0; p < NumPorts; p++) begin
      if (gnt_o[p] && !dec_hit[p] && (cnt_q[p] != CntMax)) begin
        cnt_d[p] = cnt_q[p] + 1'b1;
      end else if (!gnt_o[p] && dec_hit[p] && (cnt_q[p] != '0)) begin
        cnt_d[p] = cnt_q[p] - 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the counter array is
  // small flop storage, so it is reset like any other register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

module axi_shim_arbiter #(
  parameter int unsigned NumPorts       = 3,
  parameter int unsigned AxiNumWords    = 4,
  parameter int unsigned AxiIdWidth     = 4,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  // read requesters
  input  logic [NumPorts-1:0]                           rd_req_i,
  output logic [NumPorts-1:0]                           rd_gnt_o,
  input  logic [NumPorts-1:0][63:0]                     rd_addr_i,
  input  logic [NumPorts-1:0][$clog2(AxiNumWords)-1:0]  rd_blen_i,
  input  logic [NumPorts-1:0][1:0]                      rd_size_i,
  input  logic [NumPorts-1:0]                           rd_lock_i,
  output logic [NumPorts-1:0]                           rd_valid_o,
  output logic [NumPorts-1:0]                           rd_last_o,
  output logic [NumPorts-1:0]                           rd_exokay_o,
  output logic [63:0]                                   rd_data_o,
  input  logic [NumPorts-1:0]                           rd_rdy_i,
  // write requesters
  input  logic [NumPorts-1:0]                           wr_req_i,
  output logic [NumPorts-1:0]                           wr_gnt_o,
  input  logic [NumPorts-1:0][63:0]                     wr_addr_i,
  input  logic [NumPorts-1:0][AxiNumWords*64-1:0]       wr_data_i,
  input  logic [NumPorts-1:0][AxiNumWords*8-1:0]        wr_be_i,
  input  logic [NumPorts-1:0][$clog2(AxiNumWords)-1:0]  wr_blen_i,
  input  logic [NumPorts-1:0][1:0]                      wr_size_i,
  input  logic [NumPorts-1:0]                           wr_lock_i,
  input  logic [NumPorts-1:0][5:0]                      wr_atop_i,
  output logic [NumPorts-1:0]                           wr_valid_o,
  output logic [NumPorts-1:0]                           wr_exokay_o,
  input  logic [NumPorts-1:0]                           wr_rdy_i,
  // shim read side
  output logic                                          shim_rd_req_o,
  output logic [63:0]                                   shim_rd_addr_o,
  output logic [$clog2(AxiNumWords)-1:0]                shim_rd_blen_o,
  output logic [1:0]                                    shim_rd_size_o,
  output logic [AxiIdWidth-1:0]                         shim_rd_id_o,
  output logic                                          shim_rd_lock_o,
  input  logic                                          shim_rd_gnt_i,
  input  logic                                          shim_rd_valid_i,
  input  logic                                          shim_rd_last_i,
  input  logic [63:0]                                   shim_rd_data_i,
  input  logic [AxiIdWidth-1:0]                         shim_rd_id_i,
  input  logic                                          shim_rd_exokay_i,
  output logic                                          shim_rd_rdy_o,
  // shim write side
  output logic                                          shim_wr_req_o,
  output logic [63:0]                                   shim_wr_addr_o,
  output logic [AxiNumWords*64-1:0]                     shim_wr_data_o,
  output logic [AxiNumWords*8-1:0]                      shim_wr_be_o,
  output logic [$clog2(AxiNumWords)-1:0]                shim_wr_blen_o,
  output logic [1:0]                                    shim_wr_size_o,
  output logic [AxiIdWidth-1:0]                         shim_wr_id_o,
  output logic                                          shim_wr_lock_o,
  output logic [5:0]                                    shim_wr_atop_o,
  input  logic                                          shim_wr_gnt_i,
  input  logic                                          shim_wr_valid_i,
  input  logic [AxiIdWidth-1:0]                         shim_wr_id_i,
  input  logic                                          shim_wr_exokay_i,
  output logic                                          shim_wr_rdy_o
);

  localparam int unsigned IdxW = $clog2(NumPorts);

  logic [IdxW-1:0] rd_idx, wr_idx;
  logic            rd_done, wr_done;

  assign rd_done = shim_rd_valid_i & shim_rd_rdy_o & shim_rd_last_i;
  assign wr_done = shim_wr_valid_i & shim_wr_rdy_o;

  axi_shim_rr_arb #(
    .NumPorts      (NumPorts),
    .MaxOutstanding(MaxOutstanding),
    .AxiIdWidth    (AxiIdWidth)
  ) u_rd_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (rd_req_i),
    .shim_gnt_i(shim_rd_gnt_i),
    .rsp_done_i(rd_done),
    .rsp_id_i  (shim_rd_id_i),
    .shim_req_o(shim_rd_req_o),
    .idx_o     (rd_idx),
    .gnt_o     (rd_gnt_o)
  );

  axi_shim_rr_arb #(
    .NumPorts      (NumPorts),
    .MaxOutstanding(MaxOutstanding),
    .AxiIdWidth    (AxiIdWidth)
  ) u_wr_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (wr_req_i),
    .shim_gnt_i(shim_wr_gnt_i),
    .rsp_done_i(wr_done),
    .rsp_id_i  (shim_wr_id_i),
    .shim_req_o(shim_wr_req_o),
    .idx_o     (wr_idx),
    .gnt_o     (wr_gnt_o)
  );

  assign shim_rd_addr_o = rd_addr_i[rd_idx];
  assign shim_rd_blen_o = rd_blen_i[rd_idx];
  assign shim_rd_size_o = rd_size_i[rd_idx];
  assign shim_rd_lock_o = rd_lock_i[rd_idx];
  assign shim_rd_id_o   = AxiIdWidth'(rd_idx);

  assign shim_wr_addr_o = wr_addr_i[wr_idx];
  assign shim_wr_data_o = wr_data_i[wr_idx];
  assign shim_wr_be_o   = wr_be_i[wr_idx];
  assign shim_wr_blen_o = wr_blen_i[wr_idx];
  assign shim_wr_size_o = wr_size_i[wr_idx];
  assign shim_wr_lock_o = wr_lock_i[wr_idx];
  assign shim_wr_atop_o = wr_atop_i[wr_idx];
  assign shim_wr_id_o   = AxiIdWidth'(wr_idx);

  // IDs with no matching port keep rdy at 1 so stray responses are sunk.
  always_comb begin
    rd_valid_o    = '0;
    wr_valid_o    = '0;
    shim_rd_rdy_o = 1'b1;
    shim_wr_rdy_o = 1'b1;
    for (int unsigned p = 0; p < NumPorts; p++) begin
      if (shim_rd_id_i == AxiIdWidth'(p)) begin
        rd_valid_o[p] = shim_rd_valid_i & ~rst_i;
        shim_rd_rdy_o = rd_rdy_i[p];
      end
      if (shim_wr_id_i == AxiIdWidth'(p)) begin
        wr_valid_o[p] = shim_wr_valid_i & ~rst_i;
        shim_wr_rdy_o = wr_rdy_i[p];
      end
    end
  end

  assign rd_data_o   = shim_rd_data_i;
  assign rd_last_o   = rd_valid_o & {NumPorts{shim_rd_last_i}};
  assign rd_exokay_o = rd_valid_o & {NumPorts{shim_rd_exokay_i}};
  assign wr_exokay_o = wr_valid_o & {NumPorts{shim_wr_exokay_i}};

endmodule

// File: tb/tb_axi_shim_arbiter.sv
// Directed bench for axi_shim_arbiter: round-robin order, locking, outstanding limits,
// response routing, sinking of unknown IDs and asynchronous reset.

module tb_axi_shim_arbiter;

  localparam int P  = 3;
  localparam int W  = 4;
  localparam int IW = 4;
  localparam int MO = 2;
  localparam int BW = $clog2(W);

  logic clk = 1'b0;
  logic rst;

  logic [P-1:0]          rd_req, rd_gnt, rd_lock, rd_valid, rd_last, rd_exokay, rd_rdy;
  logic [P-1:0][63:0]    rd_addr;
  logic [P-1:0][BW-1:0]  rd_blen;
  logic [P-1:0][1:0]     rd_size;
  logic [63:0]           rd_data;

  logic [P-1:0]          wr_req, wr_gnt, wr_lock, wr_valid, wr_exokay, wr_rdy;
  logic [P-1:0][63:0]    wr_addr;
  logic [P-1:0][W*64-1:0] wr_data;
  logic [P-1:0][W*8-1:0] wr_be;
  logic [P-1:0][BW-1:0]  wr_blen;
  logic [P-1:0][1:0]     wr_size;
  logic [P-1:0][5:0]     wr_atop;

  logic          s_rd_req, s_rd_lock, s_rd_gnt, s_rd_valid, s_rd_last, s_rd_exokay, s_rd_rdy;
  logic [63:0]   s_rd_addr, s_rd_data;
  logic [BW-1:0] s_rd_blen;
  logic [1:0]    s_rd_size;
  logic [IW-1:0] s_rd_id, s_rd_rid;

  logic            s_wr_req, s_wr_lock, s_wr_gnt, s_wr_valid, s_wr_exokay, s_wr_rdy;
  logic [63:0]     s_wr_addr;
  logic [W*64-1:0] s_wr_data;
  logic [W*8-1:0]  s_wr_be;
  logic [BW-1:0]   s_wr_blen;
  logic [1:0]      s_wr_size;
  logic [IW-1:0]   s_wr_id, s_wr_bid;
  logic [5:0]      s_wr_atop;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  axi_shim_arbiter #(
    .NumPorts(P), .AxiNumWords(W), .AxiIdWidth(IW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .rd_req_i(rd_req), .rd_gnt_o(rd_gnt), .rd_addr_i(rd_addr), .rd_blen_i(rd_blen),
    .rd_size_i(rd_size), .rd_lock_i(rd_lock), .rd_valid_o(rd_valid), .rd_last_o(rd_last),
    .rd_exokay_o(rd_exokay), .rd_data_o(rd_data), .rd_rdy_i(rd_rdy),
    .wr_req_i(wr_req), .wr_gnt_o(wr_gnt), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .wr_be_i(wr_be), .wr_blen_i(wr_blen), .wr_size_i(wr_size), .wr_lock_i(wr_lock),
    .wr_atop_i(wr_atop), .wr_valid_o(wr_valid), .wr_exokay_o(wr_exokay), .wr_rdy_i(wr_rdy),
    .shim_rd_req_o(s_rd_req), .shim_rd_addr_o(s_rd_addr), .shim_rd_blen_o(s_rd_blen),
    .shim_rd_size_o(s_rd_size), .shim_rd_id_o(s_rd_id), .shim_rd_lock_o(s_rd_lock),
    .shim_rd_gnt_i(s_rd_gnt), .shim_rd_valid_i(s_rd_valid), .shim_rd_last_i(s_rd_last),
    .shim_rd_data_i(s_rd_data), .shim_rd_id_i(s_rd_rid), .shim_rd_exokay_i(s_rd_exokay),
    .shim_rd_rdy_o(s_rd_rdy),
    .shim_wr_req_o(s_wr_req), .shim_wr_addr_o(s_wr_addr), .shim_wr_data_o(s_wr_data),
    .shim_wr_be_o(s_wr_be), .shim_wr_blen_o(s_wr_blen), .shim_wr_size_o(s_wr_size),
    .shim_wr_id_o(s_wr_id), .shim_wr_lock_o(s_wr_lock), .shim_wr_atop_o(s_wr_atop),
    .shim_wr_gnt_i(s_wr_gnt), .shim_wr_valid_i(s_wr_valid), .shim_wr_id_i(s_wr_bid),
    .shim_wr_exokay_i(s_wr_exokay), .shim_wr_rdy_o(s_wr_rdy)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    rd_req = '0; rd_rdy = '1; wr_req = '0; wr_rdy = '1;
    s_rd_gnt = 1'b0; s_rd_valid = 1'b0; s_rd_last = 1'b0; s_rd_data = '0;
    s_rd_rid = '0; s_rd_exokay = 1'b0;
    s_wr_gnt = 1'b0; s_wr_valid = 1'b0; s_wr_bid = '0; s_wr_exokay = 1'b0;
    for (int p = 0; p < P; p++) begin
      rd_addr[p] = 64'h1000 + 64'(p) * 64'h100;
      rd_blen[p] = BW'(p);
      rd_size[p] = 2'd3;
      rd_lock[p] = (p == 1);
      wr_addr[p] = 64'h2000 + 64'(p) * 64'h100;
      wr_data[p] = {W{64'hA000 + 64'(p)}};
      wr_be[p]   = 32'hFFFF_0000 | 32'(p);
      wr_blen[p] = BW'(p);
      wr_size[p] = 2'd2;
      wr_lock[p] = 1'b0;
      wr_atop[p] = 6'(p + 8);
    end

    // Requests and grants present during reset must be masked.
    rd_req = 3'b111; s_rd_gnt = 1'b1;
    #2;
    check("rst_rd_gnt", rd_gnt, 3'b000);
    check("rst_rd_req", s_rd_req, 1'b0);
    tick(); tick();
    rst = 1'b0;

    // Continuous requests, shim always granting: 0,1,2,0,1,2 then all ports full.
    for (int k = 0; k < 6; k++) begin
      #1;
      check("rr_gnt", rd_gnt, 3'b001 << (k % 3));
      check("rr_id", s_rd_id, k % 3);
      check("rr_blen", s_rd_blen, k % 3);
      tick();
    end
    #1;
    check("full_no_req", s_rd_req, 1'b0);
    check("full_no_gnt", rd_gnt, 3'b000);

    // Drain two completions per port.
    rd_req = '0; s_rd_gnt = 1'b0;
    for (int k = 0; k < 6; k++) begin
      s_rd_valid = 1'b1; s_rd_last = 1'b1; s_rd_rid = IW'(k / 2);
      #1;
      check("drain_valid", rd_valid, 3'b001 << (k / 2));
      tick();
    end
    s_rd_valid = 1'b0; s_rd_last = 1'b0;

    // Port 1 locks the shim for three cycles; port 0 arrives but must wait.
    rd_req = 3'b010; s_rd_gnt = 1'b0;
    #1;
    check("lock_addr0", s_rd_addr, 64'h1100);
    check("lock_lock0", s_rd_lock, 1'b1);
    check("lock_gnt0", rd_gnt, 3'b000);
    tick();
    rd_req = 3'b011;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("lock_addr", s_rd_addr, 64'h1100);
      check("lock_gnt", rd_gnt, 3'b000);
      tick();
    end
    s_rd_gnt = 1'b1;
    #1;
    check("lock_addr3", s_rd_addr, 64'h1100);
    check("lock_gnt3", rd_gnt, 3'b010);
    tick();
    rd_req = 3'b001;
    #1;
    check("after_lock_gnt", rd_gnt, 3'b001);
    check("after_lock_addr", s_rd_addr, 64'h1000);
    tick();

    // Port 0 reaches its outstanding limit, port 1 is served instead.
    #1;
    check("p0_second_gnt", rd_gnt, 3'b001);
    tick();
    #1;
    check("p0_blocked_req", s_rd_req, 1'b0);
    tick();
    rd_req = 3'b011;
    #1;
    check("p1_served_gnt", rd_gnt, 3'b010);
    check("p1_served_id", s_rd_id, 1);
    tick();
    rd_req = 3'b001;
    s_rd_valid = 1'b1; s_rd_last = 1'b1; s_rd_rid = 4'd0; s_rd_exokay = 1'b1;
    s_rd_data = 64'hDEAD_BEEF_0000_0001;
    #1;
    check("p0_still_blocked", s_rd_req, 1'b0);
    check("r_valid_p0", rd_valid, 3'b001);
    check("r_last_p0", rd_last, 3'b001);
    check("r_exokay_p0", rd_exokay, 3'b001);
    check("r_data", rd_data, 64'hDEAD_BEEF_0000_0001);
    tick();
    s_rd_valid = 1'b0; s_rd_last = 1'b0; s_rd_exokay = 1'b0;
    #1;
    check("p0_eligible_again", rd_gnt, 3'b001);
    tick();

    // Port 2 fills up, then a burst with id 2 under a toggling ready.
    rd_req = 3'b100;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("p2_fill_gnt", rd_gnt, 3'b100);
      tick();
    end
    rd_req = '0; s_rd_gnt = 1'b0;
    s_rd_valid = 1'b1; s_rd_rid = 4'd2;
    for (int k = 0; k < 4; k++) begin
      s_rd_last = (k == 3);
      rd_rdy    = (k % 2 == 0) ? 3'b100 : 3'b011;
      #1;
      check("burst_valid", rd_valid, 3'b100);
      check("burst_rdy", s_rd_rdy, (k % 2 == 0) ? 1'b1 : 1'b0);
      check("burst_last", rd_last, (k == 3) ? 3'b100 : 3'b000);
      tick();
    end
    s_rd_valid = 1'b0; s_rd_last = 1'b0; rd_rdy = 3'b111;
    rd_req = 3'b100; s_rd_gnt = 1'b1;
    #1;
    check("p2_not_decremented", s_rd_req, 1'b0);
    tick();
    rd_req = '0; s_rd_valid = 1'b1; s_rd_last = 1'b1;
    #1;
    check("p2_last_rdy", s_rd_rdy, 1'b1);
    tick();
    s_rd_valid = 1'b0; s_rd_last = 1'b0; rd_req = 3'b100;
    #1;
    check("p2_regranted", rd_gnt, 3'b100);
    tick();
    rd_req = '0; s_rd_gnt = 1'b0;

    // Write channel: grant fields, cancelling inc/dec, unknown-ID sink.
    wr_req = 3'b010; s_wr_gnt = 1'b1;
    #1;
    check("w_gnt", wr_gnt, 3'b010);
    check("w_id", s_wr_id, 1);
    check("w_addr", s_wr_addr, 64'h2100);
    check("w_data", s_wr_data, {W{64'hA001}});
    check("w_be", s_wr_be, 32'hFFFF_0001);
    check("w_atop", s_wr_atop, 6'd9);
    tick();
    s_wr_valid = 1'b1; s_wr_bid = 4'd1;
    #1;
    check("w_gnt_and_b", wr_gnt, 3'b010);
    check("w_b_valid", wr_valid, 3'b010);
    tick();
    s_wr_valid = 1'b0;
    #1;
    check("w_gnt_third", wr_gnt, 3'b010);
    tick();
    #1;
    check("w_p1_full", s_wr_req, 1'b0);
    tick();
    wr_req = '0; s_wr_gnt = 1'b0; wr_rdy = 3'b000;
    s_wr_valid = 1'b1; s_wr_bid = 4'd7;
    #1;
    check("b7_sunk_rdy", s_wr_rdy, 1'b1);
    check("b7_no_valid", wr_valid, 3'b000);
    tick();
    s_wr_bid = 4'd1;
    #1;
    check("b1_rdy_low", s_wr_rdy, 1'b0);
    check("b1_valid", wr_valid, 3'b010);
    tick();
    s_wr_valid = 1'b0; wr_rdy = 3'b111;

    // Lock the write channel on port 0, then reset asynchronously mid-cycle.
    wr_req = 3'b001;
    #1;
    check("w_lock_req", s_wr_req, 1'b1);
    check("w_lock_id", s_wr_id, 0);
    tick();
    rst = 1'b1;
    s_wr_gnt = 1'b1; s_wr_valid = 1'b1; s_wr_bid = 4'd1;
    rd_req = 3'b111; s_rd_gnt = 1'b1; s_rd_valid = 1'b1; s_rd_rid = 4'd0;
    #1;
    check("arst_wr_gnt", wr_gnt, 3'b000);
    check("arst_wr_req", s_wr_req, 1'b0);
    check("arst_wr_valid", wr_valid, 3'b000);
    check("arst_rd_gnt", rd_gnt, 3'b000);
    check("arst_rd_req", s_rd_req, 1'b0);
    check("arst_rd_valid", rd_valid, 3'b000);
    tick();
    rst = 1'b0; s_wr_valid = 1'b0; s_rd_valid = 1'b0;
    wr_req = 3'b111;
    #1;
    check("post_rst_wr_gnt", wr_gnt, 3'b001);
    check("post_rst_rd_gnt", rd_gnt, 3'b001);
    tick();
    #1;
    check("post_rst_wr_next", wr_gnt, 3'b010);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
